// File: rtl/acc_ctrl.sv
// Accumulator RAM controller: writes systolic-array rows (overwrite or accumulate) and drains rows out.
// Optional ACC_CTRL_CLEAR_ON_DRAIN_EN: each drained row is zeroed as it handshakes out.
module acc_ctrl #(
    parameter int DATA_SIZE = 20,
    parameter int DATA_NUM  = 16,
    parameter int RAM_DEPTH = 16,
    localparam int W = DATA_NUM * DATA_SIZE,
    localparam int A = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic         cmd_op,
    input  logic         cmd_acc,
    input  logic [A-1:0] cmd_addr,
    input  logic [4:0]   cmd_len,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         acc_wea,
    output logic         acc_en,
    output logic         acc_enb,
    output logic [A-1:0] acc_addra,
    output logic [A-1:0] acc_addrb,
    output logic [W-1:0] acc_dina,
    input  logic [W-1:0] acc_doutb,
    output logic         busy,
    output logic         done
);

    typedef enum logic [1:0] {IDLE, WRITE, DRAIN, FINISH} state_t;

    state_t       state, state_nxt;
    logic [A-1:0] cur_addr, rd_addr;
    logic [4:0]   remaining, rd_left;
    logic         acc_mode;
    logic         rd_vld;
    logic         wr_fire, rd_issue, out_fire;

    // Row pointers wrap explicitly so non-power-of-two depths behave the same way.
    function automatic logic [A-1:0] addr_inc(input logic [A-1:0] a);
        if (a == A'(RAM_DEPTH - 1))
            return '0;
        else
            return a + A'(1);
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

`ifdef ACC_CTRL_CLEAR_ON_DRAIN_EN
    logic [A-1:0] out_addr;

    // Address of the row currently presented on out_data, used for the clear write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            out_addr <= '0;
        else if (rd_issue)
            out_addr <= rd_addr;
    end
`endif

    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        acc_wea   = 1'b0;
        acc_en    = 1'b0;
        acc_enb   = 1'b0;
        acc_addra = cur_addr;
        acc_addrb = rd_addr;
        acc_dina  = in_data;
        wr_fire   = 1'b0;
        rd_issue  = 1'b0;
        out_fire  = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    if (cmd_len == 5'd0)
                        state_nxt = FINISH;
                    else if (cmd_op)
                        state_nxt = WRITE;
                    else
                        state_nxt = DRAIN;
                end
            end
            WRITE: begin
                in_ready = 1'b1;
                wr_fire  = in_valid;
                acc_wea  = in_valid;
                acc_en   = acc_mode;
                if (wr_fire && remaining == 5'd1)
                    state_nxt = FINISH;
            end
            DRAIN: begin
                out_valid = rd_vld;
                rd_issue  = (rd_left != 5'd0) && (!rd_vld || out_ready);
                acc_enb   = rd_issue;
                out_fire  = rd_vld && out_ready;
`ifdef ACC_CTRL_CLEAR_ON_DRAIN_EN
                if (out_fire) begin
                    acc_wea   = 1'b1;
                    acc_en    = 1'b0;
                    acc_addra = out_addr;
                    acc_dina  = '0;
                end
`endif
                if (rd_left == 5'd0 && out_fire)
                    state_nxt = FINISH;
            end
            FINISH: begin
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Command latch, write pointer and read pipeline (rd_vld marks acc_doutb as holding a row).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur_addr  <= '0;
            rd_addr   <= '0;
            remaining <= '0;
            rd_left   <= '0;
            acc_mode  <= 1'b0;
            rd_vld    <= 1'b0;
        end else begin
            if (state == IDLE && cmd_valid) begin
                cur_addr  <= cmd_addr;
                rd_addr   <= cmd_addr;
                remaining <= cmd_len;
                rd_left   <= cmd_len;
                acc_mode  <= cmd_acc;
                rd_vld    <= 1'b0;
            end
            if (wr_fire) begin
                cur_addr  <= addr_inc(cur_addr);
                remaining <= remaining - 5'd1;
            end
            if (rd_issue) begin
                rd_addr <= addr_inc(rd_addr);
                rd_left <= rd_left - 5'd1;
                rd_vld  <= 1'b1;
            end else if (out_fire) begin
                rd_vld  <= 1'b0;
            end
        end
    end

    assign out_data = acc_doutb;
    assign busy     = (state != IDLE);
    assign done     = (state == FINISH);

endmodule

// File: doc/acc_ctrl.md
ACC_CTRL -- requirements
Module: acc_ctrl

Interface
REQ-001 Parameter DATA_SIZE, 20, bits per accumulator lane.
REQ-002 Parameter DATA_NUM, 16, lanes per row; row width W = DATA_NUM*DATA_SIZE (320).
REQ-003 Parameter RAM_DEPTH, 16, accumulator rows; address width A = clog2(RAM_DEPTH) (4).
REQ-004 Clock and reset SHALL be: one clock; reset is asynchronous and active-low (clk in 1 system clock, rising edge; reset_n in 1 async active-low reset).
REQ-005 cmd_valid in 1, cmd_ready out 1: command handshake.
REQ-006 cmd_op in 1 (1 = WRITE rows from array, 0 = DRAIN rows out); cmd_acc in 1 (WRITE only: 1 accumulate, 0 overwrite).
REQ-007 cmd_addr in A, start row; cmd_len in 5, row count.
REQ-008 in_valid in 1, in_ready out 1, in_data in W: systolic-array result rows.
REQ-009 out_valid out 1, out_ready in 1, out_data out W: drained rows.
REQ-010 acc_wea, acc_en, acc_enb out 1; acc_addra, acc_addrb out A; acc_dina out W; acc_doutb in W: accumulator ports (1-cycle read latency).
REQ-011 busy out 1, high whenever state is not IDLE; done out 1, single-cycle completion pulse.

Function
REQ-012 FSM states SHALL be IDLE, WRITE, DRAIN, FINISH; cmd_ready = 1 only in IDLE.
REQ-013 IDLE: on cmd_valid, latch addr/len/acc; cmd_len = 0 -> FINISH; else cmd_op selects WRITE or DRAIN.
REQ-014 WRITE: in_ready = 1; acc_wea = in_valid & in_ready combinationally; acc_addra = cur_addr; acc_dina = in_data; acc_en = latched cmd_acc.
REQ-015 Each write handshake SHALL increment cur_addr modulo RAM_DEPTH (15 -> 0) and decrement remaining; after the last row -> FINISH.
REQ-016 DRAIN: acc_enb = (rd_left != 0) & (!rd_vld | out_ready); acc_addrb = rd_addr; each issue increments rd_addr modulo RAM_DEPTH, decrements rd_left.
REQ-017 rd_vld SHALL set the cycle after an issue and clear on out handshake with no new issue; out_valid = rd_vld; out_data = acc_doutb.
REQ-018 With out_ready held high, DRAIN SHALL sustain one row per cycle; first out_valid one cycle after entering DRAIN.
REQ-019 While out_valid & !out_ready, acc_enb SHALL stay 0 so out_data is stable.
REQ-020 DRAIN -> FINISH when rd_left = 0 and the final row handshakes.
REQ-021 FINISH: done = 1 for one cycle, next state IDLE.
REQ-022 cmd_len > RAM_DEPTH SHALL be honoured with address wrap (rows revisited, accumulating again if cmd_acc).
REQ-023 acc_wea, acc_enb, in_ready, out_valid SHALL be 0 outside their states.

Reset
REQ-024 reset_n low SHALL immediately force IDLE; busy, done, out_valid, in_ready, acc_wea, acc_enb, acc_en = 0; counters and addresses = 0.
REQ-025 Reset mid-WRITE/DRAIN SHALL abandon the command; accumulator contents are not cleared; first command after reset_n rises is accepted normally.

Configuration
REQ-026 Macro ACC_CTRL_CLEAR_ON_DRAIN_EN defined: each DRAIN out handshake SHALL write zero to the drained row in the same cycle (acc_wea = 1, acc_en = 0, acc_dina = 0, acc_addra = that row's address).
REQ-027 Macro undefined: DRAIN SHALL never assert acc_wea; rows keep their values.

Verification
REQ-028 WRITE addr 2 len 3 acc 0, rows A,B,C -> acc_wea on 3 handshakes, addra 2,3,4, acc_en 0, done 1 cycle after row C.
REQ-029 WRITE addr 14 len 4 acc 1 -> addra 14,15,0,1, acc_en 1; then DRAIN addr 14 len 4 -> out_data equals model sums, addrb 14,15,0,1.
REQ-030 DRAIN len 16, out_ready = 1 -> 16 consecutive out_valid cycles; out_ready toggled 1010... -> no lost or duplicated row, out_data stable while stalled.
REQ-031 cmd_len 0 -> cmd_ready low 1 cycle, done pulse, no acc_wea/acc_enb.
REQ-032 reset_n pulsed low mid-DRAIN (row 5 of 10) -> out_valid 0 at once, busy 0; new DRAIN from row 0 returns correct data.
REQ-033 With ACC_CTRL_CLEAR_ON_DRAIN_EN: DRAIN addr 3 len 2, then second DRAIN -> rows 3,4 read all zero; without macro -> original values.
